// File: rtl/watch_set_cu_pkg.sv
// ============================================================================
// Module  : watch_pkg
// Brief   : Shared FSM state, field index and direction encodings for watch_set_cu
// Revision: 1.0
// ============================================================================
`default_nettype none

package watch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FIRST    = 2'd1,
    REPEAT   = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam int FLD_SEC  = 0;
  localparam int FLD_MIN  = 1;
  localparam int FLD_HOUR = 2;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Index width for n items, never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/watch_set_cu_if.sv
// ============================================================================
// Module  : watch_set_cu_if
// Brief   : Switch/button inputs and tick/grant outputs of the time-setting unit
// Revision: 1.0
// ============================================================================
`default_nettype none

interface watch_set_cu_if
  import watch_pkg::*;
#(
  parameter int NUM_FIELDS = 3,
  localparam int SEL_W     = sel_w(NUM_FIELDS)
);
  logic                  mode;
  logic [NUM_FIELDS-1:0] field_sel;
  logic                  btn_up;
  logic                  btn_down;
  logic [NUM_FIELDS-1:0] tick_up;
  logic [NUM_FIELDS-1:0] tick_down;
  logic [SEL_W-1:0]      active_idx;
  logic                  active_vld;

  modport master (
    output mode, field_sel, btn_up, btn_down,
    input  tick_up, tick_down, active_idx, active_vld
  );

  modport slave (
    input  mode, field_sel, btn_up, btn_down,
    output tick_up, tick_down, active_idx, active_vld
  );
endinterface

`default_nettype wire

// File: rtl/watch_set_cu_btn_edge.sv
// ============================================================================
// Module  : btn_edge
// Brief   : One-bit history register and rising-edge (press) detector
// Revision: 1.0
// ============================================================================
`default_nettype none

module btn_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic press
);
  logic r_hist;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_hist <= 1'b0;
    else          r_hist <= btn;
  end

  assign press = btn & ~r_hist;
endmodule

`default_nettype wire

// File: rtl/watch_set_cu.sv
// ============================================================================
// Module  : watch_set_cu
// Brief   : Turns up/down buttons into per-field set ticks; optional auto-repeat
//           enabled by WATCH_SET_AUTOREPEAT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module watch_set_cu
  import watch_pkg::*;
#(
  parameter int NUM_FIELDS = 3,
  parameter int HOLD_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000,
  localparam int SEL_W     = sel_w(NUM_FIELDS)
) (
  input  logic            clk,
  input  logic            reset_n,
  watch_set_cu_if.slave   bus
);
  if (HOLD_CYC < 2 || REPEAT_CYC < 2) begin : g_bad_param
    $error("watch_set_cu: HOLD_CYC and REPEAT_CYC must be >= 2");
  end

  logic w_up_press, w_down_press;

  btn_edge u_edge_up   (.clk(clk), .reset_n(reset_n), .btn(bus.btn_up),   .press(w_up_press));
  btn_edge u_edge_down (.clk(clk), .reset_n(reset_n), .btn(bus.btn_down), .press(w_down_press));

  // Lowest set switch wins, so scan from the top down.
  logic [SEL_W-1:0] w_idx;
  logic             w_vld;
  always_comb begin
    w_idx = '0;
    for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
      if (bus.field_sel[i]) w_idx = SEL_W'(i);
    end
    w_vld = ~bus.mode & (|bus.field_sel);
  end

  state_t                r_state, w_state_nxt;
  logic                  r_dir, w_dir_nxt;
  logic [SEL_W-1:0]      r_press_idx, w_press_idx_nxt;
  logic [SEL_W-1:0]      r_active_idx;
  logic                  r_active_vld;
  logic [NUM_FIELDS-1:0] r_tick_up, r_tick_down;
  logic                  w_fire, w_lat_held, w_opp_press, w_abort, w_allow;

`ifdef WATCH_SET_AUTOREPEAT_EN
  localparam int c_CNT_W = sel_w(max2(HOLD_CYC, REPEAT_CYC));
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_last;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_dir_nxt       = r_dir;
    w_press_idx_nxt = r_press_idx;
    w_fire          = 1'b0;
    w_allow         = r_active_vld & ~bus.mode;
    w_lat_held      = (r_dir == DIR_UP) ? bus.btn_up : bus.btn_down;
    w_opp_press     = (r_dir == DIR_UP) ? w_down_press : w_up_press;
    w_abort         = bus.mode | ~r_active_vld | (r_active_idx != r_press_idx);
`ifdef WATCH_SET_AUTOREPEAT_EN
    w_cnt_nxt  = r_cnt;
    w_cnt_last = (r_state == FIRST) ? c_CNT_W'(HOLD_CYC - 1) : c_CNT_W'(REPEAT_CYC - 1);
`endif
    case (r_state)
      IDLE: begin
        if (w_up_press & w_down_press) begin
          w_state_nxt = WAIT_REL;
        end else if ((w_up_press | w_down_press) & w_allow) begin
          w_fire          = 1'b1;
          w_dir_nxt       = w_up_press ? DIR_UP : DIR_DOWN;
          w_press_idx_nxt = r_active_idx;
          w_state_nxt     = FIRST;
`ifdef WATCH_SET_AUTOREPEAT_EN
          w_cnt_nxt       = '0;
`endif
        end
      end
      FIRST, REPEAT: begin
        if (w_opp_press | w_abort) begin
          w_state_nxt = WAIT_REL;
        end else if (!w_lat_held) begin
          w_state_nxt = IDLE;
        end
`ifdef WATCH_SET_AUTOREPEAT_EN
        else if (r_cnt == w_cnt_last) begin
          w_fire      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = REPEAT;
        end else if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
`endif
      end
      WAIT_REL: begin
        if (!bus.btn_up && !bus.btn_down) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_dir        <= DIR_UP;
      r_press_idx  <= SEL_W'(FLD_SEC);
      r_active_idx <= SEL_W'(FLD_SEC);
      r_active_vld <= 1'b0;
      r_tick_up    <= '0;
      r_tick_down  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_dir        <= w_dir_nxt;
      r_press_idx  <= w_press_idx_nxt;
      r_active_idx <= w_idx;
      r_active_vld <= w_vld;
      r_tick_up    <= (w_fire && w_dir_nxt == DIR_UP)   ? (NUM_FIELDS'(1) << r_active_idx) : '0;
      r_tick_down  <= (w_fire && w_dir_nxt == DIR_DOWN) ? (NUM_FIELDS'(1) << r_active_idx) : '0;
    end
  end

`ifdef WATCH_SET_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_cnt <= '0;
    else          r_cnt <= w_cnt_nxt;
  end
`endif

  assign bus.tick_up    = r_tick_up;
  assign bus.tick_down  = r_tick_down;
  assign bus.active_idx = r_active_idx;
  assign bus.active_vld = r_active_vld;
endmodule

`default_nettype wire

// File: tb/tb_watch_set_cu.sv
// ============================================================================
// Module  : tb_watch_set_cu
// Brief   : Directed self-checking bench for watch_set_cu (HOLD_CYC=8, REPEAT_CYC=4)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_watch_set_cu;
  localparam int NF   = 3;
  localparam int HOLD = 8;
  localparam int REP  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  watch_set_cu_if #(.NUM_FIELDS(NF)) bus ();

  watch_set_cu #(.NUM_FIELDS(NF), .HOLD_CYC(HOLD), .REPEAT_CYC(REP)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Press registered in cycle 0 ticks in cycle 1; repeats follow at HOLD+1, then every REP.
  function automatic bit exp_tick(input int c, input int hold);
    if (c == 1) return 1'b1;
`ifdef WATCH_SET_AUTOREPEAT_EN
    if (c >= HOLD + 1 && c <= hold && ((c - HOLD - 1) % REP) == 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic run_hold(input bit up, input int hold, input int total, input logic [NF-1:0] mask);
    if (up) bus.btn_up = 1'b1; else bus.btn_down = 1'b1;
    for (int c = 1; c <= total; c++) begin
      cyc();
      if (up) begin
        chk($sformatf("hold_up_c%0d", c), 32'(bus.tick_up), exp_tick(c, hold) ? 32'(mask) : 32'd0);
        chk($sformatf("hold_up_other_c%0d", c), 32'(bus.tick_down), 32'd0);
      end else begin
        chk($sformatf("hold_dn_c%0d", c), 32'(bus.tick_down), exp_tick(c, hold) ? 32'(mask) : 32'd0);
        chk($sformatf("hold_dn_other_c%0d", c), 32'(bus.tick_up), 32'd0);
      end
      if (c == hold) begin
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
      end
    end
    cyc();
    cyc();
  endtask

  initial begin
    bus.mode      = 1'b0;
    bus.field_sel = '0;
    bus.btn_up    = 1'b0;
    bus.btn_down  = 1'b0;

    // Reset state
    cyc(); cyc();
    chk("rst_tick_up",    32'(bus.tick_up),    32'd0);
    chk("rst_tick_down",  32'(bus.tick_down),  32'd0);
    chk("rst_active_idx", 32'(bus.active_idx), 32'd0);
    chk("rst_active_vld", 32'(bus.active_vld), 32'd0);
    reset_n = 1'b1;

    // Basic increment on the minute field
    bus.field_sel = 3'b010;
    cyc(); cyc();
    chk("basic_vld", 32'(bus.active_vld), 32'd1);
    chk("basic_idx", 32'(bus.active_idx), 32'd1);
    run_hold(1'b1, 3, 5, 3'b010);

    // Hold repeat on seconds, down direction
    bus.field_sel = 3'b001;
    cyc(); cyc();
    chk("rep_idx", 32'(bus.active_idx), 32'd0);
    run_hold(1'b0, 20, 24, 3'b001);

    // Priority: min beats hour
    bus.field_sel = 3'b110;
    cyc(); cyc();
    chk("prio_idx", 32'(bus.active_idx), 32'd1);
    run_hold(1'b1, 3, 5, 3'b010);

    // Stopwatch mode gates everything
    bus.mode = 1'b1;
    cyc(); cyc();
    chk("mode_vld", 32'(bus.active_vld), 32'd0);
    run_hold(1'b1, 3, 5, 3'b000);
    bus.mode = 1'b0;
    cyc(); cyc();

    // Simultaneous up/down press, then a clean up press
    bus.field_sel = 3'b001;
    cyc(); cyc();
    bus.btn_up   = 1'b1;
    bus.btn_down = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      chk($sformatf("conf_up_c%0d", c), 32'(bus.tick_up),   32'd0);
      chk($sformatf("conf_dn_c%0d", c), 32'(bus.tick_down), 32'd0);
    end
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    cyc(); cyc();
    run_hold(1'b1, 3, 5, 3'b001);

    // Selection change mid-hold: 001 -> 100 at cycle 5
    bus.btn_up = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      cyc();
      chk($sformatf("selchg_c%0d", c), 32'(bus.tick_up), (c == 1) ? 32'd1 : 32'd0);
      if (c == 5)  bus.field_sel = 3'b100;
      if (c == 12) bus.btn_up = 1'b0;
    end
    cyc(); cyc();
    run_hold(1'b1, 3, 5, 3'b100);

    // Reset asserted mid-hold while the button stays high
    bus.btn_up = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      cyc();
      chk($sformatf("prerst_c%0d", c), 32'(bus.tick_up), exp_tick(c, 99) ? 32'd4 : 32'd0);
    end
    chk("prerst_idx", 32'(bus.active_idx), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_tick_up",    32'(bus.tick_up),    32'd0);
    chk("arst_tick_down",  32'(bus.tick_down),  32'd0);
    chk("arst_active_idx", 32'(bus.active_idx), 32'd0);
    chk("arst_active_vld", 32'(bus.active_vld), 32'd0);
    cyc(); cyc();
    reset_n = 1'b1;
    // Intended: a button held through reset must not tick afterwards.
    for (int c = 1; c <= 6; c++) begin
      cyc();
      chk($sformatf("postrst_c%0d", c), 32'(bus.tick_up), 32'd0);
    end
    chk("postrst_vld", 32'(bus.active_vld), 32'd1);
    bus.btn_up = 1'b0;
    cyc(); cyc();

    // Long up hold on minutes: auto-repeat ticks, or a single tick without it
    bus.field_sel = 3'b010;
    cyc(); cyc();
    run_hold(1'b1, 20, 24, 3'b010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
